// File: rtl/ftdi_rx_deframer.sv
// ftdi_rx_deframer: splits the FTDI host byte stream into frames
// (SYNC, LEN, CMD, payload, CHK), streams the payload to the command decoder,
// and flags bad-length, bad-checksum and stalled frames before hunting for the next SYNC.
module ftdi_rx_deframer #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         MAX_LEN   = 64,
    parameter int         TIMEOUT   = 1000
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        rd,
    input  logic        rxf,
    input  logic [7:0]  q,
    output logic [7:0]  cmd,
    output logic [7:0]  pl_data,
    output logic        pl_valid,
    output logic        pl_sop,
    output logic        pl_eop,
    output logic        frm_ok,
    output logic        frm_err,
    output logic [1:0]  err_code,
    output logic        busy,
    output logic [15:0] frm_cnt,
    output logic [7:0]  err_cnt
);

    localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [15:0] IDLE_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_HUNT,
        S_LEN,
        S_CMD,
        S_PAYLOAD,
        S_CHK
    } state_t;

    state_t      state, state_n;
    logic        byte_stb;
    logic [6:0]  len, len_n;
    logic [6:0]  cnt, cnt_n;
    logic [7:0]  sum, sum_n;
    logic [15:0] idle, idle_n;
    logic [7:0]  cmd_n;
    logic [7:0]  pl_data_n;
    logic        pl_valid_n, pl_sop_n, pl_eop_n;
    logic        frm_ok_n, frm_err_n;
    logic [1:0]  err_code_n;
    logic        last_byte;

    assign byte_stb  = ~rd & ~rxf;
    assign busy      = (state != S_HUNT);
    assign last_byte = ((cnt + 7'd1) == len);

    // State register; an asynchronous reset drops any partial frame silently.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= S_HUNT;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and next-output logic; a byte in the expiry cycle beats the timeout.
    always_comb begin
        state_n    = state;
        len_n      = len;
        cnt_n      = cnt;
        sum_n      = sum;
        cmd_n      = cmd;
        pl_data_n  = pl_data;
        pl_valid_n = 1'b0;
        pl_sop_n   = 1'b0;
        pl_eop_n   = 1'b0;
        frm_ok_n   = 1'b0;
        frm_err_n  = 1'b0;
        err_code_n = err_code;

        if (state == S_HUNT || byte_stb) begin
            idle_n = 16'd0;
        end else begin
            idle_n = idle + 16'd1;
        end

        case (state)
            S_HUNT: begin
                if (byte_stb && q == SYNC_BYTE) begin
                    state_n = S_LEN;
                end
            end
            S_LEN: begin
                if (byte_stb) begin
                    if (q != 8'd0 && q <= MAX_LEN_B) begin
                        len_n   = q[6:0];
                        sum_n   = q;
                        state_n = S_CMD;
                    end else begin
                        frm_err_n  = 1'b1;
                        err_code_n = 2'd1;
                        state_n    = S_HUNT;
                    end
                end
            end
            S_CMD: begin
                if (byte_stb) begin
                    cmd_n   = q;
                    sum_n   = sum + q;
                    cnt_n   = 7'd0;
                    state_n = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (byte_stb) begin
                    pl_data_n  = q;
                    pl_valid_n = 1'b1;
                    pl_sop_n   = (cnt == 7'd0);
                    pl_eop_n   = last_byte;
                    sum_n      = sum + q;
                    cnt_n      = cnt + 7'd1;
                    if (last_byte) begin
                        state_n = S_CHK;
                    end
                end
            end
            S_CHK: begin
                if (byte_stb) begin
                    if (q == sum) begin
                        frm_ok_n = 1'b1;
                    end else begin
                        frm_err_n  = 1'b1;
                        err_code_n = 2'd2;
                    end
                    state_n = S_HUNT;
                end
            end
            default: begin
                state_n = S_HUNT;
            end
        endcase

        if (state != S_HUNT && !byte_stb && idle == IDLE_LAST) begin
            frm_err_n  = 1'b1;
            err_code_n = 2'd3;
            idle_n     = 16'd0;
            state_n    = S_HUNT;
        end
    end

    // Datapath and output registers, plus the wrapping good-frame and saturating error counters.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            len      <= 7'd0;
            cnt      <= 7'd0;
            sum      <= 8'd0;
            idle     <= 16'd0;
            cmd      <= 8'd0;
            pl_data  <= 8'd0;
            pl_valid <= 1'b0;
            pl_sop   <= 1'b0;
            pl_eop   <= 1'b0;
            frm_ok   <= 1'b0;
            frm_err  <= 1'b0;
            err_code <= 2'd0;
            frm_cnt  <= 16'd0;
            err_cnt  <= 8'd0;
        end else begin
            len      <= len_n;
            cnt      <= cnt_n;
            sum      <= sum_n;
            idle     <= idle_n;
            cmd      <= cmd_n;
            pl_data  <= pl_data_n;
            pl_valid <= pl_valid_n;
            pl_sop   <= pl_sop_n;
            pl_eop   <= pl_eop_n;
            frm_ok   <= frm_ok_n;
            frm_err  <= frm_err_n;
            err_code <= err_code_n;
            if (frm_ok_n) begin
                frm_cnt <= frm_cnt + 16'd1;
            end
            if (frm_err_n && err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_ftdi_rx_deframer.sv
// tb_ftdi_rx_deframer: directed frames with a scoreboard of expected payload
// beats and frame results, checked by a negedge monitor.
module tb_ftdi_rx_deframer;

    localparam int TIMEOUT = 1000;

    logic        clk;
    logic        n_rst;
    logic        rd;
    logic        rxf;
    logic [7:0]  q;
    logic [7:0]  cmd;
    logic [7:0]  pl_data;
    logic        pl_valid;
    logic        pl_sop;
    logic        pl_eop;
    logic        frm_ok;
    logic        frm_err;
    logic [1:0]  err_code;
    logic        busy;
    logic [15:0] frm_cnt;
    logic [7:0]  err_cnt;

    typedef struct {
        logic [7:0] data;
        logic       sop;
        logic       eop;
    } pl_exp_t;

    typedef struct {
        logic       ok;
        logic [1:0] code;
    } res_exp_t;

    pl_exp_t  exp_pl[$];
    res_exp_t exp_res[$];

    int compared   = 0;
    int mismatched = 0;

    ftdi_rx_deframer #(
        .SYNC_BYTE(8'hA5),
        .MAX_LEN  (64),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk     (clk),
        .n_rst   (n_rst),
        .rd      (rd),
        .rxf     (rxf),
        .q       (q),
        .cmd     (cmd),
        .pl_data (pl_data),
        .pl_valid(pl_valid),
        .pl_sop  (pl_sop),
        .pl_eop  (pl_eop),
        .frm_ok  (frm_ok),
        .frm_err (frm_err),
        .err_code(err_code),
        .busy    (busy),
        .frm_cnt (frm_cnt),
        .err_cnt (err_cnt)
    );

    // 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before 2 ms");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One byte presented for exactly one rising edge, starting from a negedge.
    task automatic apply_stimulus(input logic [7:0] b);
        rd  = 1'b0;
        rxf = 1'b0;
        q   = b;
        @(negedge clk);
        rd  = 1'b1;
        rxf = 1'b1;
    endtask

    // Full frame with payload base, base+0x11, ...; expectations queued before driving.
    task automatic send_frame(input logic [7:0] len_b, input logic [7:0] cmd_b,
                              input logic [7:0] base, input logic bad_chk);
        logic [7:0] s;
        logic [7:0] b;
        int         n;
        n = int'(len_b);
        apply_stimulus(8'hA5);
        apply_stimulus(len_b);
        s = len_b;
        apply_stimulus(cmd_b);
        s = s + cmd_b;
        for (int i = 0; i < n; i++) begin
            b = base + 8'(8'h11 * i);
            exp_pl.push_back('{b, (i == 0), (i == n - 1)});
            s = s + b;
            apply_stimulus(b);
        end
        if (bad_chk) begin
            exp_res.push_back('{1'b0, 2'd2});
            apply_stimulus(s + 8'd1);
        end else begin
            exp_res.push_back('{1'b1, 2'd0});
            apply_stimulus(s);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT produces a payload beat or a frame result.
    always @(negedge clk) begin
        pl_exp_t  pe;
        res_exp_t re;
        if (n_rst) begin
            if (pl_valid) begin
                check_output("pl_expected", 32'(exp_pl.size() != 0), 32'd1);
                if (exp_pl.size() != 0) begin
                    pe = exp_pl.pop_front();
                    check_output("pl_data", 32'(pl_data), 32'(pe.data));
                    check_output("pl_sop", 32'(pl_sop), 32'(pe.sop));
                    check_output("pl_eop", 32'(pl_eop), 32'(pe.eop));
                end
            end
            if (frm_ok || frm_err) begin
                check_output("ok_err_exclusive", 32'(frm_ok & frm_err), 32'd0);
                check_output("result_with_pl", 32'(pl_valid), 32'd0);
                check_output("result_expected", 32'(exp_res.size() != 0), 32'd1);
                if (exp_res.size() != 0) begin
                    re = exp_res.pop_front();
                    check_output("frm_ok", 32'(frm_ok), 32'(re.ok));
                    if (!re.ok) begin
                        check_output("err_code", 32'(err_code), 32'(re.code));
                    end
                end
            end
        end
    end

    // Directed sequence.
    initial begin
        rd    = 1'b1;
        rxf   = 1'b1;
        q     = 8'h00;
        n_rst = 1'b0;
        repeat (3) @(negedge clk);
        check_output("reset_busy", 32'(busy), 32'd0);
        check_output("reset_frm_cnt", 32'(frm_cnt), 32'd0);
        check_output("reset_err_cnt", 32'(err_cnt), 32'd0);
        check_output("reset_cmd", 32'(cmd), 32'd0);
        check_output("reset_pl_valid", 32'(pl_valid), 32'd0);
        n_rst = 1'b1;
        @(negedge clk);

        $display("[TB] good 3-byte frame");
        send_frame(8'h03, 8'h10, 8'h11, 1'b0);
        repeat (2) @(negedge clk);
        check_output("t1_cmd", 32'(cmd), 32'h10);
        check_output("t1_frm_cnt", 32'(frm_cnt), 32'd1);
        check_output("t1_busy", 32'(busy), 32'd0);

        $display("[TB] bad checksum");
        send_frame(8'h03, 8'h10, 8'h11, 1'b1);
        repeat (2) @(negedge clk);
        check_output("t2_err_code", 32'(err_code), 32'd2);
        check_output("t2_err_cnt", 32'(err_cnt), 32'd1);
        check_output("t2_frm_cnt", 32'(frm_cnt), 32'd1);

        $display("[TB] junk before sync");
        apply_stimulus(8'h00);
        apply_stimulus(8'hFF);
        apply_stimulus(8'h5A);
        check_output("t3_busy_junk", 32'(busy), 32'd0);
        send_frame(8'h03, 8'h10, 8'h11, 1'b0);
        repeat (2) @(negedge clk);
        check_output("t3_frm_cnt", 32'(frm_cnt), 32'd2);

        $display("[TB] length errors and max length");
        exp_res.push_back('{1'b0, 2'd1});
        apply_stimulus(8'hA5);
        apply_stimulus(8'h00);
        repeat (2) @(negedge clk);
        check_output("t4_len0_err_cnt", 32'(err_cnt), 32'd2);
        exp_res.push_back('{1'b0, 2'd1});
        apply_stimulus(8'hA5);
        apply_stimulus(8'h41);
        repeat (2) @(negedge clk);
        check_output("t4_len65_code", 32'(err_code), 32'd1);
        check_output("t4_len65_err_cnt", 32'(err_cnt), 32'd3);
        send_frame(8'h40, 8'hA5, 8'hA5, 1'b0);
        repeat (2) @(negedge clk);
        check_output("t4_max_frm_cnt", 32'(frm_cnt), 32'd3);
        check_output("t4_max_cmd", 32'(cmd), 32'hA5);

        $display("[TB] idle just under timeout");
        apply_stimulus(8'hA5);
        apply_stimulus(8'h03);
        apply_stimulus(8'h10);
        exp_pl.push_back('{8'h11, 1'b1, 1'b0});
        apply_stimulus(8'h11);
        repeat (TIMEOUT - 1) @(negedge clk);
        check_output("t5_busy_idle", 32'(busy), 32'd1);
        exp_pl.push_back('{8'h22, 1'b0, 1'b0});
        exp_pl.push_back('{8'h33, 1'b0, 1'b1});
        exp_res.push_back('{1'b1, 2'd0});
        apply_stimulus(8'h22);
        apply_stimulus(8'h33);
        apply_stimulus(8'h79);
        repeat (2) @(negedge clk);
        check_output("t5_frm_cnt", 32'(frm_cnt), 32'd4);

        $display("[TB] idle reaching timeout");
        apply_stimulus(8'hA5);
        apply_stimulus(8'h03);
        apply_stimulus(8'h10);
        exp_pl.push_back('{8'h11, 1'b1, 1'b0});
        apply_stimulus(8'h11);
        exp_res.push_back('{1'b0, 2'd3});
        repeat (TIMEOUT) @(negedge clk);
        check_output("t5_to_busy", 32'(busy), 32'd0);
        check_output("t5_to_code", 32'(err_code), 32'd3);
        check_output("t5_to_err_cnt", 32'(err_cnt), 32'd4);

        $display("[TB] reset mid-frame");
        apply_stimulus(8'hA5);
        apply_stimulus(8'h03);
        apply_stimulus(8'h10);
        exp_pl.push_back('{8'h11, 1'b1, 1'b0});
        apply_stimulus(8'h11);
        @(negedge clk);
        @(posedge clk);
        #2;
        n_rst = 1'b0;
        #1;
        check_output("t6_busy", 32'(busy), 32'd0);
        check_output("t6_frm_cnt", 32'(frm_cnt), 32'd0);
        check_output("t6_err_cnt", 32'(err_cnt), 32'd0);
        check_output("t6_cmd", 32'(cmd), 32'd0);
        check_output("t6_err_code", 32'(err_code), 32'd0);
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        send_frame(8'h03, 8'h10, 8'h11, 1'b0);
        repeat (2) @(negedge clk);
        check_output("t6_frm_cnt_after", 32'(frm_cnt), 32'd1);
        check_output("t6_frm_err_quiet", 32'(err_cnt), 32'd0);

        repeat (3) @(negedge clk);
        check_output("pl_queue_drained", 32'(exp_pl.size()), 32'd0);
        check_output("res_queue_drained", 32'(exp_res.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
